factorial_ctrl: RTL and testbench

- Bus-master sequencer that computes n! by driving the multiplier slave through its register map.
- Iterates acc = acc * i for i = 2..n. Each step: load operands, start, wait for m_interrupt, read the 128-bit product, clear.
- Gives the top level a simple start/done handshake, so software never polls the multiplier directly.

---
 rtl/factorial_ctrl_pkg.sv | 37 +++
 rtl/factorial_ctrl_if.sv | 12 +
 rtl/factorial_ctrl_mul_bus_if.sv | 40 ++++
 rtl/factorial_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_factorial_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/factorial_ctrl_pkg.sv
// Shared constants for the factorial sequencer: multiplier register map,
// FSM state encodings and the largest n whose factorial fits in 64 bits.
package factorial_pkg;

  localparam logic [7:0] MUL_OPA_LO  = 8'h00;
  localparam logic [7:0] MUL_OPA_HI  = 8'h01;
  localparam logic [7:0] MUL_OPB_LO  = 8'h02;
  localparam logic [7:0] MUL_OPB_HI  = 8'h03;
  localparam logic [7:0] MUL_PROD0   = 8'h04;
  localparam logic [7:0] MUL_PROD1   = 8'h05;
  localparam logic [7:0] MUL_PROD2   = 8'h06;
  localparam logic [7:0] MUL_PROD3   = 8'h07;
  localparam logic [7:0] MUL_IEN     = 8'h08;
  localparam logic [7:0] MUL_OPSTART = 8'h0a;
  localparam logic [7:0] MUL_OPCLEAR = 8'h0b;

  localparam int MAX_N_NO_OVF = 20;

  typedef logic [3:0] fact_state_t;

  localparam fact_state_t S_IDLE  = 4'd0;
  localparam fact_state_t S_IEN   = 4'd1;
  localparam fact_state_t S_LA0   = 4'd2;
  localparam fact_state_t S_LA1   = 4'd3;
  localparam fact_state_t S_LB0   = 4'd4;
  localparam fact_state_t S_LB1   = 4'd5;
  localparam fact_state_t S_GO    = 4'd6;
  localparam fact_state_t S_WAIT  = 4'd7;
  localparam fact_state_t S_RD0   = 4'd8;
  localparam fact_state_t S_RD1   = 4'd9;
  localparam fact_state_t S_RD2   = 4'd10;
  localparam fact_state_t S_RD3   = 4'd11;
  localparam fact_state_t S_CLR   = 4'd12;
  localparam fact_state_t S_CHECK = 4'd13;
  localparam fact_state_t S_DONE  = 4'd14;

endpackage

// File: rtl/factorial_ctrl_if.sv
// Bus between the factorial sequencer (master) and the multiplier slave.
interface factorial_ctrl_if;
  logic        M_sel;
  logic        M_wr;
  logic [7:0]  M_address;
  logic [31:0] M_dout;
  logic [31:0] M_din;
  logic        m_interrupt;

  modport master (output M_sel, M_wr, M_address, M_dout, input M_din, m_interrupt);
  modport slave  (input M_sel, M_wr, M_address, M_dout, output M_din, m_interrupt);
endinterface

// File: rtl/factorial_ctrl_mul_bus_if.sv
// Registered single-transfer bus driver: a request presented this cycle
// appears on the multiplier bus for exactly one cycle after the next edge.
module mul_bus_if (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  factorial_ctrl_if.master bus
);

  logic        sel_q;
  logic        wr_q;
  logic [7:0]  addr_q;
  logic [31:0] dout_q;

  // Idle bus cycles drive zeros so the slave never sees stale address/data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q  <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= 8'h00;
      dout_q <= 32'h0;
    end else begin
      sel_q  <= req;
      wr_q   <= req && wr;
      addr_q <= req ? addr : 8'h00;
      dout_q <= (req && wr) ? wdata : 32'h0;
    end
  end

  assign bus.M_sel     = sel_q;
  assign bus.M_wr      = wr_q;
  assign bus.M_address = addr_q;
  assign bus.M_dout    = dout_q;
  assign rdata         = bus.M_din;

endmodule

// File: rtl/factorial_ctrl.sv
// Computes n! by sequencing the multiplier slave over its register bus.
// Optional macro FACT_TIMEOUT_EN bounds the wait for the multiplier interrupt.
module factorial_ctrl
  import factorial_pkg::*;
#(
  parameter int ACC_W   = 64,
  parameter int N_W     = 6,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N_W-1:0]   n,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result,
  output logic             ovf,
  output logic             err,
  factorial_ctrl_if.master bus
);

  localparam int I_W = N_W + 1;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("factorial_ctrl: TIMEOUT must be at least 2");
  end

  fact_state_t      state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [I_W-1:0]   i;
  logic [N_W-1:0]   n_q;
  logic [127:0]     p;
  logic             accept, p_ovf, last;
  logic             bus_req, bus_wr;
  logic [7:0]       bus_addr;
  logic [31:0]      bus_wdata, bus_rdata;

`ifdef FACT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;
  logic             wait_expired;
  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));
`endif

  // A start landing on the done cycle is dropped so the result is seen first
  assign accept = (state == S_IDLE) && start && !done;
  assign p_ovf  = |p[127:ACC_W];
  assign last   = (i == {1'b0, n_q});

  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    bus_req   = 1'b0;
    bus_wr    = 1'b0;
    bus_addr  = 8'h00;
    bus_wdata = 32'h0;
    case (state)
      S_IDLE:  if (accept) begin
                 acc_nx   = ACC_W'(1);
                 state_nx = (n <= N_W'(1)) ? S_DONE : S_IEN;
               end
      S_IEN:   state_nx = S_LA0;
      S_LA0:   state_nx = S_LA1;
      S_LA1:   state_nx = S_LB0;
      S_LB0:   state_nx = S_LB1;
      S_LB1:   state_nx = S_GO;
      S_GO:    state_nx = S_WAIT;
      S_WAIT:  begin
                 if (bus.m_interrupt) state_nx = S_RD0;
`ifdef FACT_TIMEOUT_EN
                 else if (wait_expired) state_nx = S_CLR;
`endif
               end
      S_RD0:   state_nx = S_RD1;
      S_RD1:   state_nx = S_RD2;
      S_RD2:   state_nx = S_RD3;
      S_RD3:   state_nx = S_CLR;
      S_CLR:   begin
`ifdef FACT_TIMEOUT_EN
                 state_nx = timed_out ? S_DONE : S_CHECK;
`else
                 state_nx = S_CHECK;
`endif
               end
      S_CHECK: if (p_ovf) state_nx = S_DONE;
               else begin
                 acc_nx   = p[ACC_W-1:0];
                 state_nx = last ? S_DONE : S_LA0;
               end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    // Bus is registered, so the transfer is requested for the state being entered
    case (state_nx)
      S_IEN:  begin bus_req = 1'b1; bus_wr = 1'b1; bus_addr = MUL_IEN;     bus_wdata = 32'h1; end
      S_LA0:  begin bus_req = 1'b1; bus_wr = 1'b1; bus_addr = MUL_OPA_LO;  bus_wdata = acc_nx[31:0]; end
      S_LA1:  begin bus_req = 1'b1; bus_wr = 1'b1; bus_addr = MUL_OPA_HI;  bus_wdata = 32'(acc >> 32); end
      S_LB0:  begin bus_req = 1'b1; bus_wr = 1'b1; bus_addr = MUL_OPB_LO;  bus_wdata = 32'(i); end
      S_LB1:  begin bus_req = 1'b1; bus_wr = 1'b1; bus_addr = MUL_OPB_HI;  bus_wdata = 32'h0; end
      S_GO:   begin bus_req = 1'b1; bus_wr = 1'b1; bus_addr = MUL_OPSTART; bus_wdata = 32'h1; end
      S_RD0:  begin bus_req = 1'b1; bus_addr = MUL_PROD0; end
      S_RD1:  begin bus_req = 1'b1; bus_addr = MUL_PROD1; end
      S_RD2:  begin bus_req = 1'b1; bus_addr = MUL_PROD2; end
      S_RD3:  begin bus_req = 1'b1; bus_addr = MUL_PROD3; end
      S_CLR:  begin bus_req = 1'b1; bus_wr = 1'b1; bus_addr = MUL_OPCLEAR; bus_wdata = 32'h1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      acc    <= ACC_W'(1);
      i      <= '0;
      n_q    <= '0;
      p      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      done  <= 1'b0;
      if (accept) begin
        n_q  <= n;
        i    <= I_W'(2);
        busy <= 1'b1;
        ovf  <= 1'b0;
      end
      // Read data is valid while the read address sits on the bus
      case (state)
        S_RD0: p[31:0]   <= bus_rdata;
        S_RD1: p[63:32]  <= bus_rdata;
        S_RD2: p[95:64]  <= bus_rdata;
        S_RD3: p[127:96] <= bus_rdata;
        default: ;
      endcase
      if (state == S_CHECK) begin
        if (p_ovf)     ovf <= 1'b1;
        else if (!last) i  <= i + I_W'(1);
      end
      if (state == S_DONE) begin
        result <= acc;
        done   <= 1'b1;
        busy   <= 1'b0;
      end
    end
  end

`ifdef FACT_TIMEOUT_EN
  // wait_cnt counts cycles since the opstart write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt  <= '0;
      timed_out <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        timed_out <= 1'b0;
        err       <= 1'b0;
      end
      if (state == S_GO) wait_cnt <= CNT_W'(1);
      else if (state == S_WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
      if (state == S_WAIT && !bus.m_interrupt && wait_expired) timed_out <= 1'b1;
      if (state == S_CLR && timed_out) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  mul_bus_if u_bus (
    .clk   (clk),
    .reset (reset),
    .req   (bus_req),
    .wr    (bus_wr),
    .addr  (bus_addr),
    .wdata (bus_wdata),
    .rdata (bus_rdata),
    .bus   (bus)
  );

endmodule

// File: tb/tb_factorial_ctrl.sv
// Self-checking bench for factorial_ctrl with a behavioural multiplier slave
// and a plain-arithmetic factorial reference.
module tb_factorial_ctrl;
  import factorial_pkg::*;

  localparam int TO = 50;
  localparam logic [63:0] FACT20 = 64'h21C3677C82B40000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  n;
  logic        busy, done, ovf, err;
  logic [63:0] result;

  factorial_ctrl_if bus_if ();

  factorial_ctrl #(.ACC_W(64), .N_W(6), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .n      (n),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf),
    .err    (err),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier slave
  logic [63:0]  opa, opb;
  logic [127:0] prod;
  logic         ien, irq;
  int           irq_cnt;
  int           irq_delay = 10;
  bit           irq_off = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      opa <= '0; opb <= '0; prod <= '0; ien <= 1'b0; irq <= 1'b0; irq_cnt <= 0;
    end else begin
      if (irq_cnt > 0) begin
        irq_cnt <= irq_cnt - 1;
        if (irq_cnt == 1 && !irq_off) irq <= 1'b1;
      end
      if (bus_if.M_sel && bus_if.M_wr) begin
        case (bus_if.M_address)
          8'h00: opa[31:0]  <= bus_if.M_dout;
          8'h01: opa[63:32] <= bus_if.M_dout;
          8'h02: opb[31:0]  <= bus_if.M_dout;
          8'h03: opb[63:32] <= bus_if.M_dout;
          8'h08: ien        <= bus_if.M_dout[0];
          8'h0a: if (bus_if.M_dout[0]) begin
                   prod    <= {64'd0, opa} * {64'd0, opb};
                   irq_cnt <= irq_delay;
                 end
          8'h0b: if (bus_if.M_dout[0]) begin
                   irq <= 1'b0; irq_cnt <= 0; prod <= '0;
                 end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus_if.M_din = 32'h0;
    case (bus_if.M_address)
      8'h04: bus_if.M_din = prod[31:0];
      8'h05: bus_if.M_din = prod[63:32];
      8'h06: bus_if.M_din = prod[95:64];
      8'h07: bus_if.M_din = prod[127:96];
      default: ;
    endcase
  end
  assign bus_if.m_interrupt = irq & ien;

  // Bus / handshake monitor
  int        done_cnt, sel_cnt, opstart_cnt;
  logic [7:0] addr_log[$];
`ifdef FACT_TIMEOUT_EN
  int go_cyc, clr_cyc;
`endif
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (bus_if.M_sel) begin
      sel_cnt++;
      addr_log.push_back(bus_if.M_address);
      if (bus_if.M_wr && bus_if.M_address == 8'h0a) opstart_cnt++;
`ifdef FACT_TIMEOUT_EN
      if (bus_if.M_wr && bus_if.M_address == 8'h0a) go_cyc = cyc;
      if (bus_if.M_wr && bus_if.M_address == 8'h0b) clr_cyc = cyc;
`endif
    end
  end

  int checks = 0;
  int passes = 0;
  int start_cyc, done_cyc;
  logic busy_at_done;

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: straight iterated product with overflow detection
  task automatic ref_fact(input int nn, output logic [63:0] r, output logic o);
    logic [127:0] a, pp;
    a = 128'd1;
    o = 1'b0;
    for (int k = 2; k <= nn; k++) begin
      pp = a * 128'(k);
      if (pp[127:64] != 0) begin
        o = 1'b1;
        break;
      end
      a = pp;
    end
    r = a[63:0];
  endtask

  function automatic int bus_order_errors(input int nn);
    logic [7:0] exp_q[$];
    int errs;
    exp_q.push_back(8'h08);
    for (int k = 2; k <= nn; k++) begin
      exp_q.push_back(8'h00); exp_q.push_back(8'h01);
      exp_q.push_back(8'h02); exp_q.push_back(8'h03);
      exp_q.push_back(8'h0a);
      exp_q.push_back(8'h04); exp_q.push_back(8'h05);
      exp_q.push_back(8'h06); exp_q.push_back(8'h07);
      exp_q.push_back(8'h0b);
    end
    errs = (exp_q.size() > addr_log.size()) ? exp_q.size() - addr_log.size()
                                            : addr_log.size() - exp_q.size();
    for (int k = 0; k < exp_q.size() && k < addr_log.size(); k++)
      if (exp_q[k] !== addr_log[k]) errs++;
    return errs;
  endfunction

  task automatic wait_done(input int limit);
    int k = 0;
    while (done !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    done_cyc     = cyc;
    busy_at_done = busy;
    check_output("done_seen", done, 1);
  endtask

  task automatic apply_stimulus(input int nn, input int dly, input bit extra);
    irq_delay   = dly;
    done_cnt    = 0;
    sel_cnt     = 0;
    opstart_cnt = 0;
    addr_log.delete();
    @(negedge clk);
    n         = 6'(nn);
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    if (extra) begin
      repeat (3) @(negedge clk);
      n     = 6'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(6000);
    repeat (extra ? 20 : 3) @(negedge clk);
  endtask

  logic [63:0] exp_r;
  logic        exp_o;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    n     = '0;
    repeat (3) @(negedge clk);
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    check_output("reset_result", result, 0);
    check_output("reset_ovf", ovf, 0);
    check_output("reset_msel", bus_if.M_sel, 0);
    reset = 1'b0;

    $display("[TB] n=5");
    apply_stimulus(5, 10, 1'b0);
    check_output("n5_result", result, 120);
    check_output("n5_ovf", ovf, 0);
    check_output("n5_err", err, 0);
    check_output("n5_done_count", done_cnt, 1);
    check_output("n5_opstarts", opstart_cnt, 4);

    for (int nn = 0; nn <= 1; nn++) begin
      $display("[TB] n=%0d", nn);
      apply_stimulus(nn, 10, 1'b0);
      check_output($sformatf("n%0d_result", nn), result, 1);
      check_output($sformatf("n%0d_latency", nn), done_cyc - start_cyc, 2);
      check_output($sformatf("n%0d_msel_cycles", nn), sel_cnt, 0);
    end

    $display("[TB] n=%0d", MAX_N_NO_OVF);
    apply_stimulus(MAX_N_NO_OVF, 10, 1'b0);
    check_output("n20_result", result, FACT20);
    check_output("n20_ovf", ovf, 0);
    check_output("n20_bus_order", bus_order_errors(MAX_N_NO_OVF), 0);

    $display("[TB] n=21");
    apply_stimulus(21, 4, 1'b0);
    check_output("n21_ovf", ovf, 1);
    check_output("n21_result", result, FACT20);
    check_output("n21_busy_with_done", busy_at_done, 0);

    for (int r = 0; r < 6; r++) begin
      int nn, dly;
      nn  = $urandom_range(0, 24);
      dly = $urandom_range(1, 12);
      $display("[TB] random n=%0d delay=%0d", nn, dly);
      apply_stimulus(nn, dly, 1'b0);
      ref_fact(nn, exp_r, exp_o);
      check_output($sformatf("rand%0d_result", r), result, exp_r);
      check_output($sformatf("rand%0d_ovf", r), ovf, exp_o);
      check_output($sformatf("rand%0d_done_count", r), done_cnt, 1);
    end

    $display("[TB] start coincident with done");
    irq_delay = 5;
    @(negedge clk);
    n = 6'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000);
    n = 6'd3; start = 1'b1;
    @(negedge clk);
    check_output("start_on_done_ignored", busy, 0);
    @(negedge clk);
    start = 1'b0;
    check_output("start_after_done_accepted", busy, 1);
    wait_done(2000);
    check_output("start_after_done_result", result, 6);

    $display("[TB] reset during WAIT");
    irq_delay = 10;
    opstart_cnt = 0;
    @(negedge clk);
    n = 6'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200 && opstart_cnt == 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_output("wait_reset_busy", busy, 0);
    check_output("wait_reset_result", result, 0);
    check_output("wait_reset_done", done, 0);
    check_output("wait_reset_msel", bus_if.M_sel, 0);
    @(negedge clk);
    reset = 1'b0;

    @(negedge clk);
    n = 6'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20 && bus_if.M_sel !== 1'b1; k++) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_output("bus_reset_msel", bus_if.M_sel, 0);
    check_output("bus_reset_mdout", bus_if.M_dout, 0);
    @(negedge clk);
    reset = 1'b0;

    apply_stimulus(3, 10, 1'b1);
    check_output("after_reset_result", result, 6);
    check_output("busy_start_ignored", done_cnt, 1);

`ifdef FACT_TIMEOUT_EN
    $display("[TB] multiplier timeout");
    irq_off = 1'b1;
    apply_stimulus(5, 10, 1'b0);
    check_output("timeout_err", err, 1);
    check_output("timeout_result", result, 1);
    check_output("timeout_clr_delay", clr_cyc - go_cyc, TO);
    irq_off = 1'b0;
`else
    check_output("err_tied_low", err, 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
